// File: rtl/bcd_display_mux.sv
// -----------------------------------------------------------------------------
// bcd_display_mux
//
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// One digit is scanned per refresh slot of REFRESH_DVSR cycles. The first
// GUARD cycles of every slot keep all anodes off, so the segment lines can
// settle without ghosting into the neighbouring digit. A coherent snapshot of
// the digit bus, decimal-point requests and blanking enable is taken at every
// frame start. A count that changes mid-scan therefore never tears across the
// four digits.
//
// Ports
//   clk       : single clock, rising edge
//   reset_n   : asynchronous active-low reset
//   digits    : packed BCD {d3,d2,d1,d0}, d0 is the rightmost digit
//   dp_in     : decimal-point request per digit, active-high
//   blank_lz  : 1 enables leading-zero blanking
//   an        : anode enables, active-low, bit i drives digit i (registered)
//   seg       : segments {g,f,e,d,c,b,a}, active-low (registered)
//   dp        : decimal point, active-low (registered)
// -----------------------------------------------------------------------------
module bcd_display_mux #(
    parameter int REFRESH_DVSR = 50000,
    parameter int GUARD        = 500,
    parameter int N            = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] digits,
    input  logic [3:0]  dp_in,
    input  logic        blank_lz,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp
);

    localparam logic [N-1:0] CNT_MAX   = N'(REFRESH_DVSR - 1);
    localparam logic [N-1:0] GUARD_CNT = N'(GUARD);
    localparam logic [N-1:0] CNT_ZERO  = {N{1'b0}};
    localparam logic [N-1:0] CNT_ONE   = {{(N-1){1'b0}}, 1'b1};

    // Active-low segment pattern for one BCD nibble; non-BCD codes show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        logic [6:0] pat;
        case (bcd)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = 7'b0111111;
        endcase
        return pat;
    endfunction

    // Scan state
    logic [N-1:0] cnt_r;
    logic [1:0]   idx_r;

    // Frame snapshot
    logic [15:0]  snap_r;
    logic [3:0]   dps_r;
    logic         blz_r;

    // Registered outputs
    logic [3:0]   an_r;
    logic [6:0]   seg_r;
    logic         dp_r;

    // Combinational helpers
    logic         slot_end_s;
    logic         frame_start_s;
    logic [3:0]   digit_s;
    logic [3:0]   zero_s;
    logic [3:0]   blank_s;
    logic [3:0]   an_nxt_s;
    logic [6:0]   seg_nxt_s;
    logic         dp_nxt_s;

    assign slot_end_s    = (cnt_r == CNT_MAX);
    assign frame_start_s = (cnt_r == CNT_ZERO) && (idx_r == 2'd0);

    // Select the snapshot nibble of the digit currently being scanned.
    always_comb begin
        digit_s = snap_r[3:0];
        case (idx_r)
            2'd0:    digit_s = snap_r[3:0];
            2'd1:    digit_s = snap_r[7:4];
            2'd2:    digit_s = snap_r[11:8];
            2'd3:    digit_s = snap_r[15:12];
            default: digit_s = snap_r[3:0];
        endcase
    end

    // Leading-zero blanking: a digit blanks only if it and every digit above
    // it are literal zero; non-BCD codes break the chain. Digit 0 never blanks.
    always_comb begin
        zero_s[0]  = (snap_r[3:0]   == 4'd0);
        zero_s[1]  = (snap_r[7:4]   == 4'd0);
        zero_s[2]  = (snap_r[11:8]  == 4'd0);
        zero_s[3]  = (snap_r[15:12] == 4'd0);
        blank_s[3] = blz_r & zero_s[3];
        blank_s[2] = blank_s[3] & zero_s[2];
        blank_s[1] = blank_s[2] & zero_s[1];
        blank_s[0] = 1'b0;
    end

    // Next output values: dark during the guard interval or when blanked.
    always_comb begin
        an_nxt_s  = 4'b1111;
        seg_nxt_s = 7'h7F;
        dp_nxt_s  = 1'b1;
        if ((cnt_r < GUARD_CNT) || blank_s[idx_r]) begin
            an_nxt_s  = 4'b1111;
            seg_nxt_s = 7'h7F;
            dp_nxt_s  = 1'b1;
        end else begin
            case (idx_r)
                2'd0:    an_nxt_s = 4'b1110;
                2'd1:    an_nxt_s = 4'b1101;
                2'd2:    an_nxt_s = 4'b1011;
                2'd3:    an_nxt_s = 4'b0111;
                default: an_nxt_s = 4'b1111;
            endcase
            seg_nxt_s = seg_decode(digit_s);
            dp_nxt_s  = ~dps_r[idx_r];
        end
    end

    // Slot counter and digit index; the index advances at each slot end.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= CNT_ZERO;
            idx_r <= 2'd0;
        end else if (slot_end_s) begin
            cnt_r <= CNT_ZERO;
            idx_r <= idx_r + 2'd1;
        end else begin
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    // Frame snapshot: inputs are only captured at frame start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snap_r <= 16'h0000;
            dps_r  <= 4'b0000;
            blz_r  <= 1'b0;
        end else if (frame_start_s) begin
            snap_r <= digits;
            dps_r  <= dp_in;
            blz_r  <= blank_lz;
        end else begin
            snap_r <= snap_r;
            dps_r  <= dps_r;
            blz_r  <= blz_r;
        end
    end

    // Output registers; reset forces the display dark immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an_r  <= 4'b1111;
            seg_r <= 7'h7F;
            dp_r  <= 1'b1;
        end else begin
            an_r  <= an_nxt_s;
            seg_r <= seg_nxt_s;
            dp_r  <= dp_nxt_s;
        end
    end

    assign an  = an_r;
    assign seg = seg_r;
    assign dp  = dp_r;

endmodule

// File: tb/tb_bcd_display_mux.sv
// -----------------------------------------------------------------------------
// tb_bcd_display_mux
//
// Self-checking bench for bcd_display_mux with REFRESH_DVSR=8, GUARD=2.
// The reference model works from the cycle number since reset release: it
// derives slot, digit and guard state arithmetically and keeps the inputs seen
// at each frame-start cycle as the frame snapshot.
// -----------------------------------------------------------------------------
module tb_bcd_display_mux;

    localparam int R     = 8;
    localparam int G     = 2;
    localparam int FRAME = 4 * R;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic [15:0] digits   = 16'h1234;
    logic [3:0]  dp_in    = 4'b0100;
    logic        blank_lz = 1'b0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;

    int checks   = 0;
    int failures = 0;
    int t        = 0;

    // Model state: the inputs present at the most recent frame-start cycle.
    logic [15:0] snap_m = 16'h0000;
    logic [3:0]  dps_m  = 4'b0000;
    logic        blz_m  = 1'b0;
    logic [6:0]  seg_tab [16];

    bcd_display_mux #(
        .REFRESH_DVSR(R),
        .GUARD       (G),
        .N           (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .digits  (digits),
        .dp_in   (dp_in),
        .blank_lz(blank_lz),
        .an      (an),
        .seg     (seg),
        .dp      (dp)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    // Compare the outputs visible during cycle t against the model.
    task automatic check_outputs();
        logic [3:0] an_e;
        logic [6:0] seg_e;
        logic       dp_e;
        logic       blanked;
        int s, c, k;
        an_e  = 4'b1111;
        seg_e = 7'h7F;
        dp_e  = 1'b1;
        if (t > 0) begin
            s = t - 1;           // outputs lag the state by one cycle
            c = s % R;
            k = (s / R) % 4;
            blanked = 1'b0;
            if (blz_m && k != 0) begin
                blanked = 1'b1;
                for (int j = k; j < 4; j++)
                    if (snap_m[4*j +: 4] != 4'd0) blanked = 1'b0;
            end
            if (c >= G && !blanked) begin
                an_e[k] = 1'b0;
                seg_e   = seg_tab[snap_m[4*k +: 4]];
                dp_e    = ~dps_m[k];
            end
        end
        check_eq("an",  {12'h000, an},  {12'h000, an_e});
        check_eq("seg", {9'h000, seg},  {9'h000, seg_e});
        check_eq("dp",  {15'h0000, dp}, {15'h0000, dp_e});
    endtask

    task automatic check_dark(input string tag);
        check_eq({tag, "_an"},  {12'h000, an},  16'h000F);
        check_eq({tag, "_seg"}, {9'h000, seg},  16'h007F);
        check_eq({tag, "_dp"},  {15'h0000, dp}, 16'h0001);
    endtask

    // One clock: capture the frame snapshot at the edge ending a frame-start
    // cycle, then check the next cycle's outputs on the falling edge.
    task automatic step();
        @(posedge clk);
        if (t % FRAME == 0) begin
            snap_m = digits;
            dps_m  = dp_in;
            blz_m  = blank_lz;
        end
        t++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // Advance until the cycle number within the frame equals phase.
    task automatic run_to(input int phase);
        int budget;
        budget = 0;
        while ((t % FRAME) != phase && budget < 2 * FRAME) begin
            step();
            budget++;
        end
    endtask

    // Called on a falling edge: assert reset, confirm outputs darken before
    // any clock edge, hold, then release so the next cycle is cycle 0.
    task automatic apply_reset(input int hold);
        #1 reset_n = 1'b0;
        #1 check_dark("rst_async");
        repeat (hold) begin
            @(negedge clk);
            check_dark("rst_hold");
        end
        reset_n = 1'b1;
        t = 0;
        check_outputs();
    endtask

    function automatic logic [3:0] rand_nibble();
        logic [3:0] v;
        if ($urandom_range(0, 2) == 0) v = 4'd0;
        else v = 4'($urandom_range(0, 15));
        return v;
    endfunction

    initial begin
        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001;
        seg_tab[2]  = 7'b0100100; seg_tab[3]  = 7'b0110000;
        seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000;
        seg_tab[8]  = 7'b0000000; seg_tab[9]  = 7'b0010000;
        for (int i = 10; i < 16; i++) seg_tab[i] = 7'b0111111;

        // Reset with 1234 applied, then full scan with dp on digit 2.
        @(negedge clk);
        apply_reset(3);
        run(2 * FRAME + 4);

        // Leading-zero blanking patterns.
        digits = 16'h0005; blank_lz = 1'b1; dp_in = 4'b0000;
        run(2 * FRAME);
        digits = 16'h0000;
        run(2 * FRAME);
        digits = 16'h0105; dp_in = 4'b1111;
        run(2 * FRAME);

        // No tearing: change the count during slot 2.
        digits = 16'h1234; blank_lz = 1'b0; dp_in = 4'b0000;
        run(FRAME);
        run_to(2 * R + 3);
        digits = 16'h5678;
        run(2 * FRAME);

        // Non-BCD nibble is shown as a dash and stops the blanking chain.
        digits = 16'h00A0; blank_lz = 1'b1;
        run(2 * FRAME);

        // Randomized inputs changing at random cycles.
        for (int i = 0; i < 20 * FRAME; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                digits   = {rand_nibble(), rand_nibble(), rand_nibble(), rand_nibble()};
                dp_in    = 4'($urandom_range(0, 15));
                blank_lz = 1'($urandom_range(0, 1));
            end
            step();
        end

        // Mid-scan reset during lit part of slot 2.
        digits = 16'h1234; blank_lz = 1'b0; dp_in = 4'b0010;
        run(FRAME);
        run_to(2 * R + 3);
        apply_reset(3);
        digits = 16'h9876;
        run(2 * FRAME);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
